// File: rtl/sprite_lb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sprite_lb_pkg : shared entry layout and encodings for the sprite line     |
// | buffer. Revision: 1.0                                                     |
// +--------------------------------------------------------------------------+
package sprite_lb_pkg;

    localparam int TRANSPARENT = 0;
    localparam int FW_LAST     = 0;
    localparam int FW_FIRST    = 1;

    // Entry layout at the default widths; wider builds keep the same field order.
    typedef struct packed {
        logic       shadow;
        logic [7:0] pal;
        logic [3:0] pix;
    } lb_entry_t;

    function automatic int entry_width(input int pix_bits, input int pal_bits);
        return 1 + pal_bits + pix_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_lb_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sprite_lb_bank : one line bank with merge/forward write pipe and a        |
// | read port that clears each entry after it is read. Revision: 1.0          |
// +--------------------------------------------------------------------------+
module sprite_lb_bank
    import sprite_lb_pkg::*;
#(
    parameter int XW         = 9,
    parameter int PIX_BITS   = 4,
    parameter int PAL_BITS   = 8,
    parameter int FIRST_WINS = FW_FIRST
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wr_en_i,
    input  logic [XW-1:0]                wr_x_i,
    input  logic [PIX_BITS-1:0]          wr_pix_i,
    input  logic [PAL_BITS-1:0]          wr_pal_i,
    input  logic                         wr_shadow_i,
    input  logic                         rd_en_i,
    input  logic [XW-1:0]                rd_x_i,
    output logic [PAL_BITS+PIX_BITS:0]   rd_data_o
);

    localparam int EW = entry_width(PIX_BITS, PAL_BITS);

    logic [EW-1:0]       mem_q [0:(1<<XW)-1];

    logic                s1_v_q;
    logic [XW-1:0]       s1_x_q;
    logic [PIX_BITS-1:0] s1_pix_q;
    logic [PAL_BITS-1:0] s1_pal_q;
    logic                s1_shadow_q;
    logic [EW-1:0]       s1_old_q;
    logic [EW-1:0]       s1_old_d;

    logic                r1_v_q;
    logic [XW-1:0]       r1_x_q;
    logic [EW-1:0]       r1_data_q;

    logic [EW-1:0]       w_merged;
    logic                w_s2_we;
    logic [XW-1:0]       w_ra;
    logic [EW-1:0]       w_rdata;
    logic                w_we;
    logic [XW-1:0]       w_wa;
    logic [EW-1:0]       w_wd;

    always_comb begin
        w_merged = s1_old_q;
        w_s2_we  = 1'b0;
        if (s1_v_q) begin
            if (s1_shadow_q) begin
                w_merged[EW-1] = 1'b1;
                w_s2_we        = 1'b1;
            end else if (s1_pix_q != PIX_BITS'(TRANSPARENT)) begin
                if ((FIRST_WINS != FW_FIRST) ||
                    (s1_old_q[PIX_BITS-1:0] == PIX_BITS'(TRANSPARENT))) begin
                    w_merged = {s1_old_q[EW-1], s1_pal_q, s1_pix_q};
                    w_s2_we  = 1'b1;
                end
            end
        end
    end

    // Single read port shared by the write pipe's fetch and the display read;
    // the top never enables both on one bank in the same cycle.
    assign w_ra    = wr_en_i ? wr_x_i : rd_x_i;
    assign w_rdata = mem_q[w_ra];

    // A pixel hitting the x still in merge sees the merged value, not stale RAM.
    assign s1_old_d = (s1_v_q && (s1_x_q == wr_x_i)) ? w_merged : w_rdata;

    assign w_we = w_s2_we | r1_v_q;
    assign w_wa = w_s2_we ? s1_x_q : r1_x_q;
    assign w_wd = w_s2_we ? w_merged : '0;

    always_ff @(posedge clk_i) begin
        if (w_we) begin
            mem_q[w_wa] <= w_wd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q      <= 1'b0;
            s1_x_q      <= '0;
            s1_pix_q    <= '0;
            s1_pal_q    <= '0;
            s1_shadow_q <= 1'b0;
            s1_old_q    <= '0;
            r1_v_q      <= 1'b0;
            r1_x_q      <= '0;
            r1_data_q   <= '0;
        end else begin
            s1_v_q <= wr_en_i;
            if (wr_en_i) begin
                s1_x_q      <= wr_x_i;
                s1_pix_q    <= wr_pix_i;
                s1_pal_q    <= wr_pal_i;
                s1_shadow_q <= wr_shadow_i;
                s1_old_q    <= s1_old_d;
            end
            r1_v_q <= rd_en_i;
            if (rd_en_i) begin
                r1_x_q    <= rd_x_i;
                r1_data_q <= w_rdata;
            end
        end
    end

    assign rd_data_o = r1_data_q;

endmodule
`default_nettype wire

// File: rtl/sprite_linebuf_pp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sprite_linebuf_pp : ping-pong sprite line buffer with priority merge,     |
// | shadow plane, screen flip and clear-after-read. Revision: 1.0             |
// +--------------------------------------------------------------------------+
module sprite_linebuf_pp
    import sprite_lb_pkg::*;
#(
    parameter int XW         = 9,
    parameter int LINE_W     = 384,
    parameter int PIX_BITS   = 4,
    parameter int PAL_BITS   = 8,
    parameter int FIRST_WINS = 1
) (
    input  logic                clk_24M,
    input  logic                nRES,
    input  logic                swap,
    input  logic                wr_en,
    input  logic [XW-1:0]       wr_x,
    input  logic [PIX_BITS-1:0] wr_pix,
    input  logic [PAL_BITS-1:0] wr_pal,
    input  logic                wr_shadow,
    input  logic                rd_ce,
    input  logic [XW-1:0]       rd_x,
    input  logic                flip,
    output logic [PIX_BITS-1:0] pix_out,
    output logic [PAL_BITS-1:0] pal_out,
    output logic                shad_out,
    output logic                opaque_out,
    output logic                rd_valid,
    output logic                ovf,
    output logic                bank
);

    localparam int            EW     = entry_width(PIX_BITS, PAL_BITS);
    localparam logic [XW-1:0] LAST_X = XW'(LINE_W - 1);

    logic          bank_q, bank_d;
    logic          ovf_q, ovf_d;
    logic          r1_v_q;
    logic          r1_bank_q;
    logic          rd_valid_q;
    logic [EW-1:0] out_q;

    logic          w_wr_oob;
    logic          w_wr_ok;
    logic          w_front;
    logic          w_back;
    logic [XW-1:0] w_rd_x;
    logic [EW-1:0] w_bank_rd [2];

    assign w_wr_oob = wr_en && (wr_x > LAST_X);
    assign w_wr_ok  = wr_en && !w_wr_oob;
    // A swap takes effect for requests issued in the swap cycle itself.
    assign w_front  = bank_q ^ swap;
    assign w_back   = ~w_front;
    assign w_rd_x   = flip ? (LAST_X - rd_x) : rd_x;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            localparam logic BID = 1'(b);
            sprite_lb_bank #(
                .XW         (XW),
                .PIX_BITS   (PIX_BITS),
                .PAL_BITS   (PAL_BITS),
                .FIRST_WINS (FIRST_WINS)
            ) u_bank (
                .clk_i       (clk_24M),
                .rst_ni      (nRES),
                .wr_en_i     (w_wr_ok && (w_back == BID)),
                .wr_x_i      (wr_x),
                .wr_pix_i    (wr_pix),
                .wr_pal_i    (wr_pal),
                .wr_shadow_i (wr_shadow),
                .rd_en_i     (rd_ce && (w_front == BID)),
                .rd_x_i      (w_rd_x),
                .rd_data_o   (w_bank_rd[b])
            );
        end
    endgenerate

    always_comb begin
        bank_d = bank_q ^ swap;
        ovf_d  = (ovf_q && !swap) || w_wr_oob;
    end

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            bank_q     <= 1'b0;
            ovf_q      <= 1'b0;
            r1_v_q     <= 1'b0;
            r1_bank_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            out_q      <= '0;
        end else begin
            bank_q     <= bank_d;
            ovf_q      <= ovf_d;
            r1_v_q     <= rd_ce;
            if (rd_ce) begin
                r1_bank_q <= w_front;
            end
            rd_valid_q <= r1_v_q;
            if (r1_v_q) begin
                out_q <= w_bank_rd[r1_bank_q];
            end
        end
    end

    assign pix_out    = out_q[PIX_BITS-1:0];
    assign pal_out    = out_q[PIX_BITS +: PAL_BITS];
    assign shad_out   = out_q[EW-1];
    assign opaque_out = (out_q[PIX_BITS-1:0] != PIX_BITS'(TRANSPARENT));
    assign rd_valid   = rd_valid_q;
    assign ovf        = ovf_q;
    assign bank       = bank_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_linebuf_pp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sprite_linebuf_pp : directed scoreboard bench for sprite_linebuf_pp,   |
// | first-wins and last-wins instances side by side. Revision: 1.0            |
// +--------------------------------------------------------------------------+
module tb_sprite_linebuf_pp;
    import sprite_lb_pkg::*;

    logic       clk_24M = 1'b0;
    logic       nRES = 1'b0;
    logic       swap = 1'b0;
    logic       wr_en = 1'b0;
    logic [8:0] wr_x = '0;
    logic [3:0] wr_pix = '0;
    logic [7:0] wr_pal = '0;
    logic       wr_shadow = 1'b0;
    logic       rd_ce = 1'b0;
    logic [8:0] rd_x = '0;
    logic       flip = 1'b0;

    logic [3:0] a_pix, b_pix;
    logic [7:0] a_pal, b_pal;
    logic       a_shad, b_shad, a_opq, b_opq, a_vld, b_vld, a_ovf, b_ovf, a_bank, b_bank;

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         scrub   = 1'b0;

    string      tq[$];
    lb_entry_t  ea[$];
    lb_entry_t  eb[$];

    always #5 clk_24M = ~clk_24M;

    sprite_linebuf_pp #(.FIRST_WINS(1)) dut_a (
        .clk_24M(clk_24M), .nRES(nRES), .swap(swap), .wr_en(wr_en), .wr_x(wr_x),
        .wr_pix(wr_pix), .wr_pal(wr_pal), .wr_shadow(wr_shadow), .rd_ce(rd_ce),
        .rd_x(rd_x), .flip(flip), .pix_out(a_pix), .pal_out(a_pal), .shad_out(a_shad),
        .opaque_out(a_opq), .rd_valid(a_vld), .ovf(a_ovf), .bank(a_bank)
    );

    sprite_linebuf_pp #(.FIRST_WINS(0)) dut_b (
        .clk_24M(clk_24M), .nRES(nRES), .swap(swap), .wr_en(wr_en), .wr_x(wr_x),
        .wr_pix(wr_pix), .wr_pal(wr_pal), .wr_shadow(wr_shadow), .rd_ce(rd_ce),
        .rd_x(rd_x), .flip(flip), .pix_out(b_pix), .pal_out(b_pal), .shad_out(b_shad),
        .opaque_out(b_opq), .rd_valid(b_vld), .ovf(b_ovf), .bank(b_bank)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic lb_entry_t mk(input logic sh, input logic [7:0] pl, input logic [3:0] px);
        lb_entry_t e;
        e.shadow = sh;
        e.pal    = pl;
        e.pix    = px;
        return e;
    endfunction

    task automatic step();
        @(posedge clk_24M);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [8:0] x, input logic [3:0] px, input logic [7:0] pl, input logic sh);
        wr_en = 1'b1; wr_x = x; wr_pix = px; wr_pal = pl; wr_shadow = sh;
        step();
        wr_en = 1'b0; wr_shadow = 1'b0;
    endtask

    task automatic do_swap();
        swap = 1'b1;
        step();
        swap = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [8:0] x, input logic fl,
                      input lb_entry_t xa, input lb_entry_t xb);
        tq.push_back(tag); ea.push_back(xa); eb.push_back(xb);
        rd_ce = 1'b1; rd_x = x; flip = fl;
        step();
        rd_ce = 1'b0; flip = 1'b0;
    endtask

    // Scoreboard monitor: every display result is matched against the queue.
    always @(negedge clk_24M) begin
        if (nRES && a_vld && !scrub) begin
            if (tq.size() == 0) begin
                chk("unexpected_rd_valid", 32'(a_vld), 32'(0));
            end else begin
                string     t;
                lb_entry_t xa, xb;
                t  = tq.pop_front();
                xa = ea.pop_front();
                xb = eb.pop_front();
                chk({t, "_fw1"},     32'({a_shad, a_pal, a_pix}), 32'(xa));
                chk({t, "_fw1_opq"}, 32'(a_opq), 32'(xa.pix != 4'd0));
                chk({t, "_fw0"},     32'({b_shad, b_pal, b_pix}), 32'(xb));
                chk({t, "_fw0_vld"}, 32'(b_vld), 32'(1));
            end
        end
    end

    initial begin
        lb_entry_t z;
        z = mk(1'b0, 8'h00, 4'h0);

        // Reset state
        idle(2);
        chk("rst_bank", 32'(a_bank), 32'(0));
        chk("rst_ovf", 32'(a_ovf), 32'(0));
        chk("rst_valid", 32'(a_vld), 32'(0));
        chk("rst_data", 32'({a_shad, a_pal, a_pix, a_opq}), 32'(0));
        nRES = 1'b1;
        idle(2);

        // Read-clear both banks over the full address range
        scrub = 1'b1;
        for (int x = 0; x < 512; x++) begin rd_ce = 1'b1; rd_x = 9'(x); step(); end
        rd_ce = 1'b0;
        do_swap();
        for (int x = 0; x < 512; x++) begin rd_ce = 1'b1; rd_x = 9'(x); step(); end
        rd_ce = 1'b0;
        do_swap();
        idle(4);
        scrub = 1'b0;
        chk("scrub_bank", 32'(a_bank), 32'(0));

        // Basic write, swap, read, then cleared after a swap pair
        wr(9'd10, 4'd5, 8'h3A, 1'b0);
        do_swap();
        chk("swap_bank", 32'(a_bank), 32'(1));
        rd("basic_x10", 9'd10, 1'b0, mk(1'b0, 8'h3A, 4'd5), mk(1'b0, 8'h3A, 4'd5));
        idle(4);
        chk("hold_pix", 32'(a_pix), 32'(5));
        chk("hold_valid", 32'(a_vld), 32'(0));
        do_swap();
        do_swap();
        rd("cleared_x10", 9'd10, 1'b0, z, z);
        idle(3);

        // Back-to-back same-x writes through the forwarding path
        wr(9'd20, 4'd3, 8'h01, 1'b0);
        wr(9'd20, 4'd7, 8'h02, 1'b0);
        do_swap();
        rd("prio_x20", 9'd20, 1'b0, mk(1'b0, 8'h01, 4'd3), mk(1'b0, 8'h02, 4'd7));
        idle(3);

        // Shadow plane and transparent no-op
        wr(9'd30, 4'd9, 8'h11, 1'b0);
        wr(9'd30, 4'd0, 8'h00, 1'b1);
        wr(9'd31, 4'd0, 8'h00, 1'b1);
        wr(9'd32, 4'd0, 8'h55, 1'b0);
        do_swap();
        rd("shad_x30", 9'd30, 1'b0, mk(1'b1, 8'h11, 4'd9), mk(1'b1, 8'h11, 4'd9));
        rd("shad_x31", 9'd31, 1'b0, mk(1'b1, 8'h00, 4'd0), mk(1'b1, 8'h00, 4'd0));
        rd("transp_x32", 9'd32, 1'b0, z, z);
        idle(3);

        // Flip addressing at both line ends
        wr(9'd0, 4'd4, 8'h22, 1'b0);
        wr(9'd383, 4'd6, 8'h44, 1'b0);
        chk("last_x_no_ovf", 32'(a_ovf), 32'(0));
        do_swap();
        rd("flip_383", 9'd383, 1'b1, mk(1'b0, 8'h22, 4'd4), mk(1'b0, 8'h22, 4'd4));
        rd("flip_0", 9'd0, 1'b1, mk(1'b0, 8'h44, 4'd6), mk(1'b0, 8'h44, 4'd6));
        idle(3);

        // Swap concurrent with a write and a read while the previous write drains
        wr(9'd40, 4'd2, 8'h05, 1'b0);
        tq.push_back("drain_rd_x41"); ea.push_back(z); eb.push_back(z);
        swap = 1'b1; wr_en = 1'b1; wr_x = 9'd50; wr_pix = 4'd8; wr_pal = 8'h66;
        rd_ce = 1'b1; rd_x = 9'd41;
        step();
        swap = 1'b0; wr_en = 1'b0; rd_ce = 1'b0;
        rd("drain_x40", 9'd40, 1'b0, mk(1'b0, 8'h05, 4'd2), mk(1'b0, 8'h05, 4'd2));
        rd("drain_x50_early", 9'd50, 1'b0, z, z);
        idle(3);
        do_swap();
        rd("drain_x50", 9'd50, 1'b0, mk(1'b0, 8'h66, 4'd8), mk(1'b0, 8'h66, 4'd8));
        rd("drain_x40_gone", 9'd40, 1'b0, z, z);
        idle(3);

        // Out-of-range writes
        wr(9'd384, 4'd1, 8'h01, 1'b0);
        wr(9'd400, 4'd1, 8'h01, 1'b0);
        wr(9'd60, 4'hF, 8'hAB, 1'b0);
        chk("ovf_set", 32'(a_ovf), 32'(1));
        do_swap();
        chk("ovf_clr", 32'(a_ovf), 32'(0));
        rd("oob_x384", 9'd384, 1'b0, z, z);
        rd("oob_x400", 9'd400, 1'b0, z, z);
        rd("valid_x60", 9'd60, 1'b0, mk(1'b0, 8'hAB, 4'hF), mk(1'b0, 8'hAB, 4'hF));
        idle(3);
        wr(9'd500, 4'd2, 8'h02, 1'b0);
        chk("ovf_set2", 32'(a_ovf), 32'(1));

        // Asynchronous reset mid-line with a write in flight
        wr(9'd70, 4'd3, 8'h33, 1'b0);
        #2 nRES = 1'b0;
        #1;
        chk("arst_bank", 32'(a_bank), 32'(0));
        chk("arst_ovf", 32'(a_ovf), 32'(0));
        chk("arst_valid", 32'(a_vld), 32'(0));
        chk("arst_data", 32'({a_shad, a_pal, a_pix, a_opq}), 32'(0));
        idle(2);
        nRES = 1'b1;
        idle(6);

        chk("scoreboard_drained", 32'(tq.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_linebuf_pp.md
Name: sprite_linebuf_pp

Overview:
- Parametrised double-buffered (ping-pong) sprite line buffer, successor to the fixed 051937-class line RAM block.
- The sprite renderer writes pixels for line N+1 into the back bank while video scans line N out of the front bank.
- Adds configurable width/depth, first-wins or last-wins priority, a separate shadow plane, screen flip, and clear-after-read.
- Sits between the sprite serializer (upstream) and the priority mixer (downstream, same domain as OB/SHAD/NCO0).

Parameters:
- XW, 9: x address width; each bank holds 2**XW entries.
- LINE_W, 384: visible entries per line; must be ≤ 2**XW.
- PIX_BITS, 4: pixel code width; code 0 is transparent.
- PAL_BITS, 8: palette/attribute width stored per entry.
- FIRST_WINS, 1: 1 = the first opaque write to an x is kept; 0 = the last opaque write wins.

Ports:
- clk_24M  in  1  system clock.
- nRES  in  1  asynchronous active-low reset.
- swap  in  1  one-cycle pulse at line boundary; exchanges front and back banks.
- wr_en  in  1  write strobe for one sprite pixel.
- wr_x  in  XW  target x in the back bank.
- wr_pix  in  PIX_BITS  pixel code.
- wr_pal  in  PAL_BITS  palette/attribute.
- wr_shadow  in  1  shadow pixel: sets the shadow bit only, colour is untouched.
- rd_ce  in  1  display pixel enable; one read per assertion.
- rd_x  in  XW  display x.
- flip  in  1  screen flip; effective read address = LINE_W-1-rd_x.
- pix_out  out  PIX_BITS  front-bank pixel code.
- pal_out  out  PAL_BITS  front-bank palette.
- shad_out  out  1  front-bank shadow bit.
- opaque_out  out  1  pix_out != 0.
- rd_valid  out  1  outputs correspond to a rd_ce issued 2 cycles earlier.
- ovf  out  1  sticky: a write with wr_x ≥ LINE_W occurred; cleared by swap.
- bank  out  1  current front bank index.

Behaviour:
- Reset (nRES low, asynchronous): bank=0, ovf=0, rd_valid=0, all data outputs 0, pipelines flushed. RAM contents are undefined after reset; the first line after reset may show garbage. The bench must swap twice (full read-clear pass) before checking data.
- Entry format is {shadow, pal, pix}. Both banks are dual-port arrays: one read port and one write port per bank per cycle.
- Write pipeline, 2 stages, each stage tagged with the bank it targets, latched at stage 1:
  - S1: read the existing entry at wr_x.
  - S2: compute the merged entry and write it back.
- Merge rules:
  - wr_shadow=1: set shadow=1; keep existing pal/pix.
  - wr_pix=0 and not shadow: no write.
  - Otherwise, FIRST_WINS=1: write {old shadow, wr_pal, wr_pix} only if old pix=0.
  - Otherwise, FIRST_WINS=0: always write {old shadow, wr_pal, wr_pix}.
- Back-to-back writes to the same x: forward the S2 result into S1's old value. There are no stalls and the bubble-free throughput is 1 pixel/cycle.
- wr_x ≥ LINE_W: the write is dropped and ovf is set.
- Read pipeline, 2 stages:
  - R1: read the front bank at the effective address.
  - R2: register the outputs, assert rd_valid for 1 cycle, and write zero to the same address in the same bank (clear-after-read).
- When rd_ce=0, data outputs hold their last values and rd_valid=0.
- Swap:
  - On the swap pulse, bank toggles on the next edge and ovf clears.
  - In-flight write and read stages complete on their tagged bank. No write ever lands in the new front bank, and no clear ever lands in the new back bank.
- Simultaneous swap and wr_en: the write targets the new back bank, which is the old front bank.
- Simultaneous swap and rd_ce: the read targets the new front bank.
- Swap with an unread front bank: entries not read persist into the next back-bank cycle. The display is required to read all LINE_W positions per line.
- Read and write never address the same bank in the same cycle, except for tagged drain cycles. Those drain cycles touch different addresses by construction.

Decomposition:
- Shared package sprite_lb_pkg holds:
  - the entry struct {shadow, pal, pix} with its width function;
  - constants TRANSPARENT=0 and the FIRST_WINS encoding.
- One natural sub-module: sprite_lb_bank. It contains one bank array plus its merge/forward write pipe and its read/clear port, instantiated twice.
- The top level holds the bank select, swap tagging, flip address math, ovf and the output mux.

Test Plan:
- Write wr_x=10, pix=5, pal=0x3A; swap; rd_ce at x=10 -> 2 cycles later pix_out=5, pal_out=0x3A, opaque_out=1, rd_valid=1. Re-read x=10 after another swap pair -> pix_out=0 (cleared).
- FIRST_WINS=1: consecutive cycles write x=20 pix=3 then pix=7 -> readback pix=3. Repeat with FIRST_WINS=0 -> pix=7. This exercises the forwarding path.
- Write x=30 pix=9 pal=0x11, then wr_shadow at x=30 and at x=31 -> x=30 reads {shad=1, pix=9, pal=0x11}; x=31 reads {shad=1, pix=0, opaque_out=0}.
- flip=1, LINE_W=384: write x=0 pix=4; swap; read rd_x=383 -> pix_out=4.
- Issue wr_en at x=50 in the same cycle as swap, with the previous write still in S2 -> the earlier write appears on the next line and the x=50 write appears one line later. Front-bank reads during the drain are unaffected.
- Write wr_x=400 -> ovf=1, no RAM change; swap -> ovf=0. Assert nRES mid-line -> all outputs 0 and bank=0 immediately, without waiting for a clock.
